// File: rtl/uart_pkg.sv
// Shared definitions for the 8051 serial receive path.
// Holds FIFO sizing defaults, SCON bit indices and the RI state type.
package uart_pkg;
  localparam int BYTE_W         = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int AW_DEF         = $clog2(FIFO_DEPTH_DEF);
  localparam int SCON_RI        = 0;
  localparam int SCON_REN       = 4;

  typedef enum logic {
    RI_CLEAR   = 1'b0,
    RI_PENDING = 1'b1
  } ri_state_t;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver <-> controller handshake: byte-complete pulse, data, enable.
// master = UART receiver, slave = uart_rx_ctrl.
import uart_pkg::*;

interface uart_rx_ctrl_if;
  logic              i_rx_complete;
  logic [BYTE_W-1:0] i_rx_data;
  logic              o_rx_en;

  modport master (
    output i_rx_complete,
    output i_rx_data,
    input  o_rx_en
  );

  modport slave (
    input  i_rx_complete,
    input  i_rx_data,
    output o_rx_en
  );
endinterface

// File: rtl/rx_fifo.sv
// Receive byte FIFO: storage, wrap-bit pointers and registered occupancy.
// Ports: i_push/i_pop (pre-qualified), i_flush, i_wdata; o_rdata=head, o_full, o_empty, o_count.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [BYTE_W-1:0] i_wdata,
  output logic [BYTE_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_flush) begin
      // memory is intentionally left intact
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_pop)
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_count <= r_count + (AW+1)'(i_push)
                         - (AW+1)'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8051 serial receive controller: REN gating, SBUF FIFO, RI/overrun flags, IRQ.
// Ports: i_clk/i_rst, rx (receiver handshake), REN/ES, SBUF read, RI/ovr clears, flush, status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_rx_ctrl_if.slave     rx,
  input  logic              i_ren,
  input  logic              i_es,
  input  logic              i_sbuf_rd,
  output logic [BYTE_W-1:0] o_sbuf,
  input  logic              i_ri_clr,
  input  logic              i_ovr_clr,
  input  logic              i_flush,
  output logic              o_ri,
  output logic              o_ovr,
  output logic [AW:0]       o_count,
  output logic              o_irq
);

  logic      r_rx_en;
  logic      r_ovr;
  ri_state_t r_ri_state;
  ri_state_t w_ri_next;

  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_ovr_set;
  logic [AW:0] w_count_next;

  // flush overrides every FIFO/flag update
  assign w_pop  = i_sbuf_rd & ~w_empty & ~i_flush;
  assign w_push = rx.i_rx_complete & ~i_flush
                & (~w_full | w_pop);
  assign w_ovr_set = rx.i_rx_complete & ~i_flush
                   & w_full & ~w_pop;

  assign w_count_next = o_count
                      + (AW+1)'(w_push)
                      - (AW+1)'(w_pop);

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_wdata (rx.i_rx_data),
    .o_rdata (o_sbuf),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_en <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_rx_en <= i_ren;
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (i_ovr_clr && !i_flush)
        r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_ri_state <= RI_CLEAR;
    else
      r_ri_state <= w_ri_next;
  end

  // clearing RI while bytes remain re-asserts it
  always_comb begin
    w_ri_next = r_ri_state;
    if (i_flush)
      w_ri_next = RI_CLEAR;
    else if (w_push)
      w_ri_next = RI_PENDING;
    else if (i_ri_clr)
      w_ri_next = (w_count_next != '0) ? RI_PENDING
                                        : RI_CLEAR;
  end

  assign rx.o_rx_en = r_rx_en;
  assign o_ri       = (r_ri_state == RI_PENDING);
  assign o_ovr      = r_ovr;
  assign o_irq      = o_ri & i_es;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ren, es, sbuf_rd, ri_clr, ovr_clr, flush;
  logic [7:0]    sbuf;
  logic          ri, ovr, irq;
  logic [AW:0]   count;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .AW         (AW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .rx        (rx_if),
    .i_ren     (ren),
    .i_es      (es),
    .i_sbuf_rd (sbuf_rd),
    .o_sbuf    (sbuf),
    .i_ri_clr  (ri_clr),
    .i_ovr_clr (ovr_clr),
    .i_flush   (flush),
    .o_ri      (ri),
    .o_ovr     (ovr),
    .o_count   (count),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       rc;
    bit [7:0] d;
    bit       rd;
    bit       ric;
    bit       oc;
    bit       fl;
    bit       ren;
    bit       es;
    bit       e_ri;
    bit       e_ovr;
    int       e_cnt;
    int       e_sbuf;
    bit       e_rxen;
  } vec_t;

  vec_t tbl[$];

  // reference model: FIFO as a plain queue
  bit [7:0] m_q[$];
  bit       m_ri, m_ovr, m_rxen;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    bit rst_, bit rc_, bit [7:0] d_, bit rd_, bit ric_, bit oc_,
    bit fl_, bit ren_, bit es_, bit eri, bit eovr, int ecnt,
    int esb, bit erx);
    vec_t v;
    v.rst = rst_; v.rc = rc_; v.d = d_; v.rd = rd_;
    v.ric = ric_; v.oc = oc_; v.fl = fl_; v.ren = ren_;
    v.es = es_; v.e_ri = eri; v.e_ovr = eovr;
    v.e_cnt = ecnt; v.e_sbuf = esb; v.e_rxen = erx;
    return v;
  endfunction

  task automatic model(input vec_t v);
    bit pop_, push_, full_;
    if (v.rst) begin
      m_q.delete();
      m_ri = 0; m_ovr = 0; m_rxen = 0;
    end else begin
      m_rxen = v.ren;
      if (v.fl) begin
        m_q.delete();
        m_ri = 0;
      end else begin
        full_ = (m_q.size() == DEPTH);
        pop_  = v.rd && (m_q.size() > 0);
        push_ = v.rc && (!full_ || pop_);
        if (pop_) void'(m_q.pop_front());
        if (push_) m_q.push_back(v.d);
        if (push_) m_ri = 1;
        else if (v.ric) m_ri = (m_q.size() != 0);
        if (v.rc && full_ && !pop_) m_ovr = 1;
        else if (v.oc) m_ovr = 0;
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    rst = v.rst;
    rx_if.i_rx_complete = v.rc;
    rx_if.i_rx_data = v.d;
    sbuf_rd = v.rd; ri_clr = v.ric; ovr_clr = v.oc;
    flush = v.fl; ren = v.ren; es = v.es;
    @(posedge clk);
    #1;
    model(v);
    chk({tag, "_m_cnt"}, int'(count), m_q.size());
    chk({tag, "_m_ri"}, int'(ri), int'(m_ri));
    chk({tag, "_m_ovr"}, int'(ovr), int'(m_ovr));
    chk({tag, "_m_rxen"}, int'(rx_if.o_rx_en), int'(m_rxen));
    chk({tag, "_m_irq"}, int'(irq), int'(m_ri & v.es));
    if (m_q.size() > 0)
      chk({tag, "_m_sbuf"}, int'(sbuf), int'(m_q[0]));
  endtask

  initial begin
    rst = 1; rx_if.i_rx_complete = 0; rx_if.i_rx_data = 0;
    sbuf_rd = 0; ri_clr = 0; ovr_clr = 0; flush = 0;
    ren = 0; es = 0;

    // rst rc d rd ric oc fl ren es | ri ovr cnt sbuf rxen
    tbl.push_back(mk(1,0,8'h00,0,0,0,0,0,0, 0,0,0,8'h00,0));
    tbl.push_back(mk(0,0,8'h00,0,0,0,0,1,0, 0,0,0,8'h00,1));
    tbl.push_back(mk(0,1,8'hA5,0,0,0,0,1,1, 1,0,1,8'hA5,1));
    tbl.push_back(mk(0,0,8'h00,1,1,0,0,1,0, 0,0,0,-1,1));
    tbl.push_back(mk(0,1,8'h11,0,0,0,0,1,0, 1,0,1,8'h11,1));
    tbl.push_back(mk(0,1,8'h22,0,0,0,0,1,1, 1,0,2,8'h11,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,0,1,8'h22,1));
    tbl.push_back(mk(0,0,8'h00,0,1,0,0,1,0, 1,0,1,8'h22,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,0,0,-1,1));
    tbl.push_back(mk(0,0,8'h00,0,1,0,0,1,0, 0,0,0,-1,1));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(0,1,8'(k),0,0,0,0,1,0,
                       1,(k==5),(k<4)?k:4,8'h01,1));
    for (int k = 2; k <= 5; k++)
      tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0,
                       1,1,5-k,(k<5)?k:-1,1));
    tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,0, 1,0,0,-1,1));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0,1,8'(8'h60+k),0,0,0,0,1,0,
                       1,0,k,8'h61,1));
    tbl.push_back(mk(0,1,8'h55,1,0,0,0,1,1, 1,0,4,8'h62,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,0,3,8'h63,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,0,2,8'h64,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,0,1,8'h55,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,0,0,-1,1));
    tbl.push_back(mk(0,0,8'h00,0,1,0,0,1,0, 0,0,0,-1,1));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(0,1,8'(8'h30+k),0,0,0,0,1,0,
                       1,(k==5),(k<4)?k:4,8'h31,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,1,3,8'h32,1));
    tbl.push_back(mk(0,0,8'h00,1,0,0,0,1,0, 1,1,2,8'h33,1));
    tbl.push_back(mk(0,1,8'h99,0,0,0,1,1,0, 0,1,0,-1,1));
    tbl.push_back(mk(0,1,8'h77,0,0,0,0,1,1, 1,1,1,8'h77,1));
    tbl.push_back(mk(0,1,8'h78,0,0,0,0,1,0, 1,1,2,8'h77,1));
    tbl.push_back(mk(0,1,8'h79,0,0,0,0,1,0, 1,1,3,8'h77,1));
    tbl.push_back(mk(1,1,8'hAA,0,0,0,0,1,1, 0,0,0,8'h00,0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0,1,8'(8'h40+k),0,0,0,0,1,0,
                       1,0,k,8'h41,1));
    tbl.push_back(mk(0,1,8'h45,0,0,1,0,1,0, 1,1,4,8'h41,1));
    tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,0, 1,0,4,8'h41,1));

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      step(tbl[i], t);
      chk({t, "_ri"}, int'(ri), int'(tbl[i].e_ri));
      chk({t, "_ovr"}, int'(ovr), int'(tbl[i].e_ovr));
      chk({t, "_cnt"}, int'(count), tbl[i].e_cnt);
      chk({t, "_rxen"}, int'(rx_if.o_rx_en), int'(tbl[i].e_rxen));
      if (tbl[i].e_sbuf >= 0)
        chk({t, "_sbuf"}, int'(sbuf), tbl[i].e_sbuf);
    end

    for (int n = 0; n < 800; n++) begin
      vec_t v;
      v = mk(0,0,8'h00,0,0,0,0,0,0, 0,0,0,-1,0);
      v.rst = ($urandom_range(0, 99) < 2);
      v.fl  = ($urandom_range(0, 99) < 4);
      v.rc  = ($urandom_range(0, 99) < 45);
      v.d   = 8'($urandom);
      v.rd  = ($urandom_range(0, 99) < 35);
      v.ric = ($urandom_range(0, 99) < 25);
      v.oc  = ($urandom_range(0, 99) < 10);
      v.ren = 1'($urandom);
      v.es  = 1'($urandom);
      step(v, $sformatf("r%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
